// File: rtl/spi_slave_stream.sv
// spi_slave_stream: SPI slave with input synchronisers, all four modes, any word width,
// either bit order, back-to-back words per CS frame and truncated-frame detection.
module spi_slave_stream #(
    parameter int WIDTH     = 16,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1,
    parameter int SYNC_STG  = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             spi_cs_n,
    input  logic             spi_sck,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_load,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             busy
);
    localparam int   CW       = $clog2(WIDTH + 1);
    localparam logic IDLE_SCK = CPOL != 0;
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t              state;
    logic [SYNC_STG-1:0] cs_q, sck_q, mosi_q;
    logic                cs_d, sck_d;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    rx_sh, tx_sh, rx_next;
    logic                cs_s, sck_s, mosi_s, cs_fall, cs_rise, lead, trail, sample_e, shift_e, done;
    assign cs_s     = cs_q[SYNC_STG-1];
    assign sck_s    = sck_q[SYNC_STG-1];
    assign mosi_s   = mosi_q[SYNC_STG-1];
    assign cs_fall  = cs_d && !cs_s;
    assign cs_rise  = !cs_d && cs_s;
    assign lead     = sck_d == IDLE_SCK && sck_s != IDLE_SCK;
    assign trail    = sck_d != IDLE_SCK && sck_s == IDLE_SCK;
    assign sample_e = CPHA != 0 ? trail : lead;
    assign shift_e  = CPHA != 0 ? lead : trail;
    assign done     = sample_e && cnt == CW'(WIDTH - 1);
    assign rx_next  = MSB_FIRST != 0 ? {rx_sh[WIDTH-2:0], mosi_s} : {mosi_s, rx_sh[WIDTH-1:1]};
    assign busy        = state == ACTIVE;
    assign spi_miso_oe = busy;
    assign spi_miso    = busy && (MSB_FIRST != 0 ? tx_sh[WIDTH-1] : tx_sh[0]);
    // A shift edge seen with cnt==0 follows a (re)load, so the fresh word's first bit is held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cs_q      <= '1;
            sck_q     <= {SYNC_STG{IDLE_SCK}};
            mosi_q    <= '0;
            cs_d      <= 1'b1;
            sck_d     <= IDLE_SCK;
            state     <= IDLE;
            cnt       <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            rx_data   <= '0;
            tx_load   <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cs_q      <= {cs_q[SYNC_STG-2:0], spi_cs_n};
            sck_q     <= {sck_q[SYNC_STG-2:0], spi_sck};
            mosi_q    <= {mosi_q[SYNC_STG-2:0], spi_mosi};
            cs_d      <= cs_s;
            sck_d     <= sck_s;
            tx_load   <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (state == IDLE) begin
                if (cs_fall) begin
                    state   <= ACTIVE;
                    tx_sh   <= tx_data;
                    tx_load <= 1'b1;
                    cnt     <= '0;
                end
            end else if (cs_rise) begin
                state <= IDLE;
                cnt   <= '0;
                if (done) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end else begin
                    frame_err <= cnt != '0;
                end
            end else if (sample_e) begin
                rx_sh <= rx_next;
                if (done) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                    cnt      <= '0;
                    tx_sh    <= tx_data;
                    tx_load  <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (shift_e && cnt != '0) begin
                tx_sh <= MSB_FIRST != 0 ? tx_sh << 1 : tx_sh >> 1;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_stream.sv
// tb_spi_slave_stream: drives an SPI master model into four 16-bit mode instances and one
// 8-bit LSB-first instance, checking received words, MISO words and pulse counts.
module tb_spi_slave_stream;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [4:0]  cs_n = 5'b11111;
    logic [4:0]  sck = 5'b01100;
    logic        mosi = 1'b0;
    logic [15:0] tx_data = 16'h0;
    logic [4:0]  miso, oe, tx_l, rx_v, f_err, bsy;
    logic [15:0] rx_d [5];
    logic [7:0]  rx8;
    int          checks = 0, errors = 0;
    int          cur = 0, cyc = 0, last_smp = 0, lat = -1, n_load = 0, n_ferr = 0;
    logic [15:0] mosi_w[$], txw[$], rx_got[$], miso_w[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_slave_stream #(.WIDTH(16), .CPOL(g / 2), .CPHA(g % 2)) u_dut (
            .clk(clk), .resetn(resetn), .spi_cs_n(cs_n[g]), .spi_sck(sck[g]), .spi_mosi(mosi),
            .spi_miso(miso[g]), .spi_miso_oe(oe[g]), .tx_data(tx_data), .tx_load(tx_l[g]),
            .rx_data(rx_d[g]), .rx_valid(rx_v[g]), .frame_err(f_err[g]), .busy(bsy[g]));
    end
    spi_slave_stream #(.WIDTH(8), .MSB_FIRST(0)) u_lsb8 (
        .clk(clk), .resetn(resetn), .spi_cs_n(cs_n[4]), .spi_sck(sck[4]), .spi_mosi(mosi),
        .spi_miso(miso[4]), .spi_miso_oe(oe[4]), .tx_data(tx_data[7:0]), .tx_load(tx_l[4]),
        .rx_data(rx8), .rx_valid(rx_v[4]), .frame_err(f_err[4]), .busy(bsy[4]));
    assign rx_d[4] = {8'h00, rx8};

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            if (rx_v[cur]) begin rx_got.push_back(rx_d[cur]); lat = cyc - last_smp; end
            if (tx_l[cur]) begin n_load++; if (txw.size() > 0) tx_data = txw.pop_front(); end
            if (f_err[cur]) n_ferr++;
        end
    endtask

    task automatic clear_obs(input int s);
        cur = s; rx_got.delete(); miso_w.delete(); n_load = 0; n_ferr = 0; lat = -1;
    endtask

    // Master: sends nbits from mosi_w, collects MISO words; abort>=0 stops mid-frame with CS low.
    task automatic xfer(input int s, input int nbits, input int half, input int abort, input bit cs_last);
        int w, cp, ch, pos;
        bit msb;
        logic [15:0] cw, mw;
        w = s == 4 ? 8 : 16; cp = s < 4 ? s / 2 : 0; ch = s < 4 ? s % 2 : 0; msb = s != 4; cw = 0;
        clear_obs(s);
        tx_data = txw.pop_front();
        cs_n[s] = 1'b0;
        tick(half + 4);
        for (int i = 0; i < nbits; i++) begin
            if (i == abort) return;
            mw = mosi_w[i / w];
            pos = msb ? w - 1 - i % w : i % w;
            if (ch == 0) begin
                mosi = mw[pos];
                tick(half);
                cw[pos] = miso[s]; last_smp = cyc; sck[s] = (cp == 0);
                if (i == nbits - 1 && cs_last) cs_n[s] = 1'b1;
                tick(half);
                sck[s] = (cp != 0);
            end else begin
                sck[s] = (cp == 0); mosi = mw[pos];
                tick(half);
                cw[pos] = miso[s]; last_smp = cyc; sck[s] = (cp != 0);
                if (i == nbits - 1 && cs_last) cs_n[s] = 1'b1;
                tick(half);
            end
            if (i % w == w - 1) begin miso_w.push_back(cw); cw = 0; end
        end
        tick(half);
        cs_n[s] = 1'b1;
        tick(8);
    endtask

    task automatic test_reset;
        tick(3);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rx_d[i], bsy[i], oe[i], miso[i], rx_v[i], tx_l[i], f_err[i]} !== 22'h0) begin
                errors++; $display("FAIL reset_outputs[%0d]: got %h expected 0", i, {rx_d[i], bsy[i], oe[i], miso[i], rx_v[i], tx_l[i], f_err[i]});
            end
        end
        resetn = 1'b1;
        tick(5);
        checks++; if (bsy !== 5'b0) begin errors++; $display("FAIL busy_after_reset: got %b expected 00000", bsy); end
    endtask

    task automatic test_mode0;
        int half = int'($urandom_range(8, 4));
        mosi_w = '{16'hA5C3}; txw = '{16'h53F0};
        xfer(0, 16, half, -1, 1'b0);
        checks++; if (rx_got.size() !== 1) begin errors++; $display("FAIL m0_rx_count: got %0d expected 1", rx_got.size()); end
        checks++; if (rx_got[0] !== 16'hA5C3) begin errors++; $display("FAIL m0_rx_word: got %h expected a5c3", rx_got[0]); end
        checks++; if (miso_w[0] !== 16'h53F0) begin errors++; $display("FAIL m0_miso_word: got %h expected 53f0", miso_w[0]); end
        checks++; if (n_load !== 2) begin errors++; $display("FAIL m0_tx_load: got %0d expected 2", n_load); end
        checks++; if (n_ferr !== 0) begin errors++; $display("FAIL m0_frame_err: got %0d expected 0", n_ferr); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL m0_latency: got %0d expected 3", lat); end
        checks++; if (rx_d[0] !== 16'hA5C3) begin errors++; $display("FAIL m0_rx_data_hold: got %h expected a5c3", rx_d[0]); end
    endtask

    task automatic test_modes;
        logic [15:0] m, t;
        for (int md = 1; md < 4; md++) begin
            for (int k = 0; k < 2; k++) begin
                m = k == 0 ? 16'h1234 : 16'($urandom);
                t = k == 0 ? 16'hBEEF : 16'($urandom);
                mosi_w = '{m}; txw = '{t};
                xfer(md, 16, int'($urandom_range(8, 4)), -1, 1'b0);
                checks++; if (rx_got.size() !== 1 || rx_got[0] !== m) begin errors++; $display("FAIL mode%0d_rx: got %h (n=%0d) expected %h", md, rx_got[0], rx_got.size(), m); end
                checks++; if (miso_w[0] !== t) begin errors++; $display("FAIL mode%0d_miso: got %h expected %h", md, miso_w[0], t); end
                checks++; if (n_load !== 2 || n_ferr !== 0) begin errors++; $display("FAIL mode%0d_pulses: got load=%0d ferr=%0d expected load=2 ferr=0", md, n_load, n_ferr); end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_rx[$], exp_tx[$];
        int md, nw;
        for (int r = 0; r < 2; r++) begin
            md = r == 0 ? 0 : int'($urandom_range(3, 0));
            nw = r == 0 ? 3 : int'($urandom_range(4, 2));
            exp_rx.delete(); exp_tx.delete();
            for (int k = 0; k < nw; k++) begin
                exp_rx.push_back(r == 0 ? (k == 0 ? 16'h0001 : k == 1 ? 16'h8000 : 16'hFFFF) : 16'($urandom));
                exp_tx.push_back(r == 0 ? (k == 0 ? 16'hAAAA : k == 1 ? 16'h5555 : 16'h0F0F) : 16'($urandom));
            end
            mosi_w = exp_rx; txw = exp_tx;
            xfer(md, 16 * nw, int'($urandom_range(8, 4)), -1, 1'b0);
            checks++; if (rx_got.size() !== nw) begin errors++; $display("FAIL burst%0d_rx_count: got %0d expected %0d", r, rx_got.size(), nw); end
            for (int k = 0; k < nw; k++) begin
                checks++; if (rx_got[k] !== exp_rx[k]) begin errors++; $display("FAIL burst%0d_rx[%0d]: got %h expected %h", r, k, rx_got[k], exp_rx[k]); end
                checks++; if (miso_w[k] !== exp_tx[k]) begin errors++; $display("FAIL burst%0d_miso[%0d]: got %h expected %h", r, k, miso_w[k], exp_tx[k]); end
            end
            checks++; if (n_load !== nw + 1 || n_ferr !== 0) begin errors++; $display("FAIL burst%0d_pulses: got load=%0d ferr=%0d expected load=%0d ferr=0", r, n_load, n_ferr, nw + 1); end
        end
    endtask

    task automatic test_partial;
        logic [15:0] prev, m;
        prev = rx_d[0];
        mosi_w = '{16'($urandom)}; txw = '{16'($urandom)};
        xfer(0, 9, int'($urandom_range(8, 4)), -1, 1'b0);
        checks++; if (n_ferr !== 1) begin errors++; $display("FAIL partial_frame_err: got %0d expected 1", n_ferr); end
        checks++; if (rx_got.size() !== 0) begin errors++; $display("FAIL partial_rx_valid: got %0d expected 0", rx_got.size()); end
        checks++; if (rx_d[0] !== prev) begin errors++; $display("FAIL partial_rx_hold: got %h expected %h", rx_d[0], prev); end
        m = 16'($urandom);
        mosi_w = '{m}; txw = '{16'($urandom)};
        xfer(0, 16, int'($urandom_range(8, 4)), -1, 1'b0);
        checks++; if (rx_got.size() !== 1 || rx_got[0] !== m || n_ferr !== 0) begin errors++; $display("FAIL partial_recover: got %h ferr=%0d expected %h ferr=0", rx_got[0], n_ferr, m); end
    endtask

    task automatic test_cs_on_last;
        logic [15:0] m = 16'($urandom);
        int md = int'($urandom_range(3, 0));
        mosi_w = '{m}; txw = '{16'($urandom)};
        xfer(md, 16, int'($urandom_range(8, 4)), -1, 1'b1);
        checks++; if (rx_got.size() !== 1 || rx_got[0] !== m) begin errors++; $display("FAIL cslast_rx: got %h (n=%0d) expected %h", rx_got[0], rx_got.size(), m); end
        checks++; if (n_load !== 1 || n_ferr !== 0) begin errors++; $display("FAIL cslast_pulses: got load=%0d ferr=%0d expected load=1 ferr=0", n_load, n_ferr); end
    endtask

    task automatic test_glitch;
        clear_obs(0);
        cs_n[0] = 1'b0;
        tick(1);
        cs_n[0] = 1'b1;
        tick(8);
        checks++; if (n_load !== 1 || n_ferr !== 0 || rx_got.size() !== 0) begin errors++; $display("FAIL glitch: got load=%0d ferr=%0d rx=%0d expected 1 0 0", n_load, n_ferr, rx_got.size()); end
        checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", bsy[0]); end
    endtask

    task automatic test_reset_mid;
        mosi_w = '{16'($urandom)}; txw = '{16'($urandom)};
        xfer(0, 16, 5, 8, 1'b0);
        checks++; if (bsy[0] !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b expected 1", bsy[0]); end
        resetn = 1'b0;
        #1;
        checks++;
        if ({rx_d[0], bsy[0], oe[0], miso[0], rx_v[0], tx_l[0], f_err[0]} !== 22'h0) begin
            errors++; $display("FAIL midreset_outputs: got %h expected 0", {rx_d[0], bsy[0], oe[0], miso[0], rx_v[0], tx_l[0], f_err[0]});
        end
        cs_n[0] = 1'b1; sck[0] = 1'b0;
        tick(3);
        resetn = 1'b1;
        tick(4);
        mosi_w = '{16'hC0DE}; txw = '{16'($urandom)};
        xfer(0, 16, int'($urandom_range(8, 4)), -1, 1'b0);
        checks++; if (rx_d[0] !== 16'hC0DE || rx_got.size() !== 1) begin errors++; $display("FAIL midreset_new_frame: got %h (n=%0d) expected c0de", rx_d[0], rx_got.size()); end
        checks++; if (n_ferr !== 0) begin errors++; $display("FAIL midreset_frame_err: got %0d expected 0", n_ferr); end
    endtask

    task automatic test_lsb8;
        logic [15:0] t;
        clear_obs(4);
        for (int k = 0; k < 6; k++) begin sck[4] = ~sck[4]; tick(4); end
        checks++; if (n_load !== 0 || n_ferr !== 0 || rx_got.size() !== 0 || bsy[4] !== 1'b0) begin errors++; $display("FAIL idle_sck: got load=%0d ferr=%0d rx=%0d busy=%b expected 0 0 0 0", n_load, n_ferr, rx_got.size(), bsy[4]); end
        for (int k = 0; k < 2; k++) begin
            mosi_w = '{k == 0 ? 16'h0001 : {8'h00, 8'($urandom)}};
            t = {8'h00, 8'($urandom)};
            txw = '{t};
            xfer(4, 8, int'($urandom_range(8, 4)), -1, 1'b0);
            checks++; if (rx_d[4] !== mosi_w[0] || rx_got.size() !== 1) begin errors++; $display("FAIL lsb8_rx[%0d]: got %h (n=%0d) expected %h", k, rx_d[4], rx_got.size(), mosi_w[0]); end
            checks++; if (miso_w[0] !== t || n_ferr !== 0) begin errors++; $display("FAIL lsb8_miso[%0d]: got %h ferr=%0d expected %h ferr=0", k, miso_w[0], n_ferr, t); end
        end
    endtask

    initial begin
        test_reset;
        test_mode0;
        test_modes;
        test_back_to_back;
        test_partial;
        test_cs_on_last;
        test_glitch;
        test_reset_mid;
        test_lsb8;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
